relu_pool: RTL and testbench
============================

RELU_POOL -- requirements
Module: relu_pool

Interface
REQ-001 SHALL have parameter IN_W, default 19: signed accumulator word width.
REQ-002 SHALL have parameter OUT_W, default 8: unsigned activation width.
REQ-003 SHALL have parameter SHIFT, default 8: requantization right-shift.
REQ-004 SHALL have parameter FMAP_W, default 26: conv output columns; must be even and ≥2.
REQ-005 SHALL have parameter FMAP_H, default 26: conv output rows; must be even and ≥2.
REQ-006 SHALL have these ports; one clock; reset is asynchronous and active-low:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort/restart.
- in_valid  in  1  accumulator word present.
- in_data  in  IN_W  signed accumulator result, raster order.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_valid  out  1  pooled activation present.
- out_data  out  OUT_W  pooled activation.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- frame_done  out  1  one-cycle pulse on the final pooled output of a frame.

Function
REQ-007 SHALL requantize each accepted word combinationally: negative → 0 (ReLU), else in_data >>> SHIFT, saturated to 2^OUT_W-1.
REQ-008 SHALL track col (0..FMAP_W-1), row (0..FMAP_H-1) and a 2-state FSM, ROW_EVEN/ROW_ODD, advanced only on accepted words.
REQ-009 SHALL hold the even-column value in a pair register; on the odd column it forms hmax = max(pair, current).
REQ-010 SHALL, in ROW_EVEN, write hmax to line buffer entry col/2 (FMAP_W/2 entries × OUT_W); no output.
REQ-011 SHALL, in ROW_ODD at odd col, load out_data = max(hmax, linebuf[col/2]) and set out_valid on the next clock edge (latency 1 cycle from acceptance).
REQ-012 SHALL drive in_ready = !out_valid || out_ready; in_ready is independent of in_valid.
REQ-013 SHALL hold out_data stable while out_valid && !out_ready; out_valid clears on handshake unless a new result loads the same cycle.
REQ-014 SHALL transition at col wrap: col=FMAP_W-1 → col=0; ROW_EVEN→ROW_ODD; ROW_ODD→ROW_EVEN, row+1.
REQ-015 SHALL wrap at row=FMAP_H-1, col=FMAP_W-1: row=0, ROW_EVEN, and assert frame_done with that output's out_valid rising edge (one cycle).
REQ-016 SHALL give clear priority over an acceptance in the same cycle: counters, FSM and out_valid zeroed; pending output discarded; line buffer contents need not be cleared.
REQ-017 SHALL produce out_valid, out_data and frame_done values that are independent of stale line-buffer contents after reset or clear, because every ROW_ODD read follows a ROW_EVEN write.

Reset
REQ-018 SHALL, on rst low, asynchronously set col=0, row=0, state=ROW_EVEN, pair=0, out_valid=0, out_data=0, frame_done=0; in_ready reads 1.
REQ-019 SHALL tolerate reset assertion mid-frame: the next frame starts at col 0, row 0, with no spurious out_valid.

Structure
REQ-020 SHALL place the FSM state encoding and the default OUT_W/SHIFT constants in the shared CNN package.
REQ-021 SHALL implement the line buffer as sub-module pool_line_buf (single-port, synchronous write, combinational read, no reset on storage).

Verification (FMAP_W=4, FMAP_H=2, SHIFT=8, OUT_W=8)
REQ-022 Row0 = 256,512,-5,1024; row1 = 768,0,2048,300, always ready → outputs 3 then 8, frame_done with the second output.
REQ-023 in_data=100000 (→390) → saturates to 255 when pooled.
REQ-024 All eight words negative → outputs 0,0.
REQ-025 out_ready low for 3 cycles with out_valid high → in_ready=0, out_data held, no input consumed.
REQ-026 clear asserted after row0 col2 → no output; a subsequent full frame yields the expected values from REQ-022.
REQ-027 rst pulsed low mid-row1 → all outputs at reset values; next frame correct.

Source files
------------

// File: rtl/relu_pool_pkg.sv
// relu_pool_pkg: shared CNN constants and pooling FSM encoding.
package relu_pool_pkg;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_SHIFT = 8;
  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} pool_state_e;
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: single-port line buffer, synchronous write, combinational read, no storage reset.
module pool_line_buf #(
  parameter int DEPTH = 13,
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem[addr_i] <= wdata_i;
  assign rdata_o = mem[addr_i];
endmodule

// File: rtl/relu_pool.sv
// relu_pool: ReLU + requantize + 2x2 max-pool over a raster-order accumulator stream.
module relu_pool
  import relu_pool_pkg::*;
#(
  parameter int IN_W = 19,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int FMAP_W = 26,
  parameter int FMAP_H = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   frame_done
);
  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int AW = (FMAP_W / 2 > 1) ? $clog2(FMAP_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);
  localparam logic [IN_W-1:0] SAT = IN_W'((1 << OUT_W) - 1);
  pool_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [OUT_W-1:0] pair_q, pair_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic acc, we, load, col_end;
  logic [IN_W-1:0] sh;
  logic [OUT_W-1:0] act, hmax, lb_rd;
  function automatic logic [OUT_W-1:0] mx(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
    return a > b ? a : b;
  endfunction
  assign in_ready = !out_valid_q || out_ready;
  always_comb begin
    acc = in_valid && in_ready;
    sh = in_data >>> SHIFT;
    act = in_data[IN_W-1] ? '0 : (sh > SAT ? '1 : sh[OUT_W-1:0]);
    hmax = mx(pair_q, act);
    col_end = col_q == COL_LAST;
    we = acc && state_q == ROW_EVEN && col_q[0];
    load = acc && state_q == ROW_ODD && col_q[0];
    col_d = !acc ? col_q : (col_end ? '0 : col_q + 1'b1);
    state_d = (acc && col_end) ? (state_q == ROW_EVEN ? ROW_ODD : ROW_EVEN) : state_q;
    row_d = !(acc && col_end) ? row_q : (row_q == ROW_LAST ? '0 : row_q + 1'b1);
    pair_d = (acc && !col_q[0]) ? act : pair_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d = load ? mx(hmax, lb_rd) : out_data_q;
    frame_done_d = load && col_end && row_q == ROW_LAST;
    // Abort wins over a same-cycle acceptance; stale line-buffer data is always overwritten before use.
    if (clear) begin
      col_d = '0;
      row_d = '0;
      state_d = ROW_EVEN;
      out_valid_d = 1'b0;
      frame_done_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ROW_EVEN;
      col_q <= '0;
      row_q <= '0;
      pair_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      pair_q <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  pool_line_buf #(.DEPTH(FMAP_W / 2), .W(OUT_W), .AW(AW)) u_lb (
    .clk(clk),
    .we_i(we),
    .addr_i(AW'(col_q >> 1)),
    .wdata_i(hmax),
    .rdata_o(lb_rd)
  );
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_pool.sv
// tb_relu_pool: directed 4x2 frames with hand-computed pooled results.
module tb_relu_pool;
  localparam int IN_W = 19;
  localparam int OUT_W = 8;
  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready;
  logic signed [IN_W-1:0] in_data;
  logic in_ready, out_valid, frame_done;
  logic [OUT_W-1:0] out_data;
  int n_cmp = 0, n_bad = 0, fd_cnt = 0;
  int got_q[$], fd_q[$];
  int fa[8] = '{256, 512, -5, 1024, 768, 0, 2048, 300};
  int fs[8] = '{100000, 0, 0, 0, 0, 0, 0, 65279};
  int fn[8] = '{-1, -256, -100000, -5, -7, -1, -131072, -2};
  relu_pool #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(8), .FMAP_W(4), .FMAP_H(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      fd_q.push_back(int'(frame_done));
    end
    if (frame_done) fd_cnt++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data = IN_W'(v);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_frame(input int f[8]);
    for (int i = 0; i < 8; i++) send(f[i]);
  endtask
  task automatic check_frame(input string tag, input int e0, input int e1);
    repeat (4) @(negedge clk);
    chk({tag, ".count"}, got_q.size(), 2);
    chk({tag, ".out0"}, got_q.size() > 0 ? got_q[0] : -1, e0);
    chk({tag, ".out1"}, got_q.size() > 1 ? got_q[1] : -1, e1);
    chk({tag, ".fd0"}, fd_q.size() > 0 ? fd_q[0] : -1, 0);
    chk({tag, ".fd1"}, fd_q.size() > 1 ? fd_q[1] : -1, 1);
    chk({tag, ".fd_pulses"}, fd_cnt, 1);
    got_q.delete();
    fd_q.delete();
    fd_cnt = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), 0);
    chk({tag, ".out_data"}, int'(out_data), 0);
    chk({tag, ".frame_done"}, int'(frame_done), 0);
    chk({tag, ".in_ready"}, int'(in_ready), 1);
  endtask
  initial begin
    rst = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    send_frame(fa);
    check_frame("basic", 3, 8);
    send_frame(fs);
    check_frame("sat", 255, 254);
    send_frame(fn);
    check_frame("neg", 0, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(fa[i]);
    in_valid = 1'b1;
    in_data = IN_W'(2048);
    repeat (3) begin
      @(negedge clk);
      chk("stall.in_ready", int'(in_ready), 0);
      chk("stall.out_valid", int'(out_valid), 1);
      chk("stall.out_data", int'(out_data), 3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    in_valid = 1'b0;
    send(2048);
    send(300);
    check_frame("stall", 3, 8);
    send(256);
    send(512);
    send(-5);
    in_valid = 1'b1;
    in_data = IN_W'(9999);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    send_frame(fa);
    check_frame("clear", 3, 8);
    for (int i = 0; i < 5; i++) send(fa[i]);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    @(posedge clk);
    #1 rst = 1'b1;
    send_frame(fa);
    check_frame("after_reset", 3, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
